// File: rtl/mux_share_arbiter_if.sv
// Handshake bundle between the two requesters/consumer and the mux-share arbiter.
// The arbiter uses the slave modport; the requester/consumer side uses master.
interface mux_share_arbiter_if;
    logic req_a;
    logic req_b;
    logic ready;
    logic grant_a;
    logic grant_b;
    logic S;
    logic E;
    logic beat;
    logic burst_done;

    modport slave (
        input  req_a,
        input  req_b,
        input  ready,
        output grant_a,
        output grant_b,
        output S,
        output E,
        output beat,
        output burst_done
    );

    modport master (
        output req_a,
        output req_b,
        output ready,
        input  grant_a,
        input  grant_b,
        input  S,
        input  E,
        input  beat,
        input  burst_done
    );
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared quad 2:1 mux; grant/S/E registered, 1 cycle from request.
// Backpressure: ready=0 stalls the beat count; bursts of BURST beats, then re-arbitrate.
module mux_share_arbiter #(
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_share_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(BURST - 1);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       last_q, last_d;   // 0 = A served last, 1 = B served last
    logic       s_q, s_d;
    logic       burst_done_q, burst_done_d;
    logic       owned;
    logic       beat_int;

    assign owned    = (state_q == GRANT_A) || (state_q == GRANT_B);
    assign beat_int = owned && bus.ready;

    assign bus.grant_a    = (state_q == GRANT_A);
    assign bus.grant_b    = (state_q == GRANT_B);
    assign bus.S          = s_q;
    assign bus.E          = !owned;
    assign bus.beat       = beat_int;
    assign bus.burst_done = burst_done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        s_d          = s_q;
        burst_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || last_q)) begin
                    state_d = GRANT_A;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    s_d     = 1'b0;
                end else if (bus.req_b) begin
                    state_d = GRANT_B;
                    cnt_d   = '0;
                    last_d  = 1'b1;
                    s_d     = 1'b1;
                end
            end
            GRANT_A: begin
                if (!bus.req_a) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (beat_int && cnt_q == CNT_LAST) begin
                    burst_done_d = 1'b1;
                    cnt_d        = '0;
                    // Hand over without a bubble if B is already waiting.
                    if (bus.req_b) begin
                        state_d = GRANT_B;
                        last_d  = 1'b1;
                        s_d     = 1'b1;
                    end
                end else if (beat_int) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            GRANT_B: begin
                if (!bus.req_b) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (beat_int && cnt_q == CNT_LAST) begin
                    burst_done_d = 1'b1;
                    cnt_d        = '0;
                    if (bus.req_a) begin
                        state_d = GRANT_A;
                        last_d  = 1'b0;
                        s_d     = 1'b0;
                    end
                end else if (beat_int) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= 1'b1;
            s_q          <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            s_q          <= s_d;
            burst_done_q <= burst_done_d;
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed-vector bench for mux_share_arbiter (BURST=4) with a queue-based scoreboard.
// Each row: inputs for one cycle and the outputs expected during that same cycle.
module tb_mux_share_arbiter;

    logic clk = 1'b0;
    logic rst;

    mux_share_arbiter_if bus ();

    mux_share_arbiter #(.BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {rst, req_a, req_b, ready} _ {grant_a, grant_b, S, E, burst_done, beat}
    localparam int NVEC = 32;
    localparam logic [9:0] VEC [NVEC] = '{
        10'b1111_000100,  // 0  held in reset
        10'b0111_000100,  // 1  tie after reset -> A
        10'b0111_100001,  // 2  A cnt0
        10'b0111_100001,  // 3  A cnt1
        10'b0111_100001,  // 4  A cnt2
        10'b0111_100001,  // 5  A cnt3 -> switch to B
        10'b0111_011011,  // 6  B, burst_done, no bubble
        10'b0111_011001,  // 7
        10'b0111_011001,  // 8
        10'b0111_011001,  // 9  B cnt3 -> back to A
        10'b0101_100011,  // 10 A, burst_done; B drops, single requester
        10'b0101_100001,  // 11
        10'b0101_100001,  // 12
        10'b0101_100001,  // 13 A cnt3, nobody waiting -> stay A
        10'b0111_100011,  // 14 A, burst_done, cnt0 -> 1
        10'b0011_100001,  // 15 A cnt1, release (beat output still high)
        10'b0011_000100,  // 16 IDLE bubble, no burst_done
        10'b0011_011001,  // 17 B cnt0
        10'b0011_011001,  // 18 B cnt1
        10'b0010_011000,  // 19 B cnt2 stall
        10'b0010_011000,  // 20 stall
        10'b0010_011000,  // 21 stall
        10'b0011_011001,  // 22 ready rises, cnt2 -> 3
        10'b0011_011001,  // 23 cnt3 -> burst end, stay B
        10'b0011_011011,  // 24 burst_done two cycles after ready rose
        10'b0011_011001,  // 25
        10'b0011_011001,  // 26
        10'b1111_011001,  // 27 B cnt3, reset asserted
        10'b0111_000100,  // 28 reset values; tie -> A
        10'b0000_100000,  // 29 A, no ready, release
        10'b0000_000100,  // 30 IDLE
        10'b0000_000100   // 31 IDLE holds
    };

    logic [5:0] exp_q [$];
    int         n_vec  = 0;
    int         n_miss = 0;

    // Monitor: compare outputs mid-cycle against the oldest queued expectation.
    initial begin
        logic [5:0] exp_v;
        logic [5:0] act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {bus.grant_a, bus.grant_b, bus.S, bus.E, bus.burst_done, bus.beat};
                if (act_v !== exp_v) begin
                    n_miss++;
                    $display("FAIL vec%0d {ga,gb,S,E,bd,beat} got %b want %b", n_vec, act_v, exp_v);
                end
                if (bus.grant_a && bus.grant_b) begin
                    n_miss++;
                    $display("FAIL vec%0d both_grants got 11 want not 11", n_vec);
                end
                n_vec++;
            end
        end
    end

    initial begin
        logic [9:0] row;
        rst       = 1'b1;
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        bus.ready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            #1;
            row       = VEC[i];
            rst       = row[9];
            bus.req_a = row[8];
            bus.req_b = row[7];
            bus.ready = row[6];
            exp_q.push_back(row[5:0]);
            @(posedge clk);
        end

        #1;
        rst       = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        bus.ready = 1'b0;
        repeat (3) @(posedge clk);

        if (exp_q.size() != 0 || n_vec != NVEC) begin
            n_miss++;
            $display("FAIL drain checked %0d want %0d", n_vec, NVEC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
